// File: rtl/inst_encoder.sv
// RV32 instruction encoder: packs a field bundle into a 32-bit word behind a 2-entry FIFO.
// Optional macro INST_ENCODER_CHECK_EN adds opcode/class and immediate-range legality checks.
module inst_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  itype,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [7:0]  err_cnt
);

  localparam logic [2:0]  R_TYPE    = 3'd0;
  localparam logic [2:0]  I_TYPE    = 3'd1;
  localparam logic [2:0]  S_TYPE    = 3'd2;
  localparam logic [2:0]  B_TYPE    = 3'd3;
  localparam logic [2:0]  U_TYPE    = 3'd4;
  localparam logic [2:0]  J_TYPE    = 3'd5;
  localparam logic [2:0]  NULL_TYPE = 3'd6;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

`ifdef INST_ENCODER_CHECK_EN
  // Opcode must belong to the class and the immediate must fit the class's encodable range.
  function automatic logic fields_legal(input logic [2:0] t, input logic [6:0] op,
                                        input logic [31:0] im);
    logic ok;
    ok = 1'b0;
    case (t)
      R_TYPE:  ok = (op == 7'b0110011);
      I_TYPE:  ok = ((op == 7'b0010011) || (op == 7'b1100111) ||
                     (op == 7'b0000011) || (op == 7'b1110011)) &&
                    (im[31:11] == {21{im[11]}});
      S_TYPE:  ok = (op == 7'b0100011) && (im[31:11] == {21{im[11]}});
      B_TYPE:  ok = (op == 7'b1100011) && (im[31:12] == {20{im[12]}}) && (im[0] == 1'b0);
      U_TYPE:  ok = ((op == 7'b0110111) || (op == 7'b0010111)) && (im[11:0] == 12'h000);
      J_TYPE:  ok = (op == 7'b1101111) && (im[31:20] == {12{im[20]}}) && (im[0] == 1'b0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction
`endif

  logic [31:0] raw_word_s;
  logic        class_ok_s;
  logic        legal_s;
  logic [31:0] enc_word_s;
  logic        enc_err_s;
  logic        push_s;
  logic        pop_s;

  logic [31:0] mem_word_r [2];
  logic        mem_err_r  [2];
  logic        wr_ptr_r;
  logic        rd_ptr_r;
  logic [1:0]  count_r;
  logic [7:0]  err_cnt_r;

  // Field packing per instruction class; unused fields of a class never reach the word.
  always_comb begin
    raw_word_s = NOP_WORD;
    class_ok_s = 1'b0;
    case (itype)
      R_TYPE: begin
        raw_word_s = {funct7, rs2, rs1, funct3, rd, opcode};
        class_ok_s = 1'b1;
      end
      I_TYPE: begin
        raw_word_s = {imm[11:0], rs1, funct3, rd, opcode};
        class_ok_s = 1'b1;
      end
      S_TYPE: begin
        raw_word_s = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        class_ok_s = 1'b1;
      end
      B_TYPE: begin
        raw_word_s = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        class_ok_s = 1'b1;
      end
      U_TYPE: begin
        raw_word_s = {imm[31:12], rd, opcode};
        class_ok_s = 1'b1;
      end
      J_TYPE: begin
        raw_word_s = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        class_ok_s = 1'b1;
      end
      default: begin
        raw_word_s = NOP_WORD;
        class_ok_s = 1'b0;
      end
    endcase
  end

`ifdef INST_ENCODER_CHECK_EN
  assign legal_s = fields_legal(itype, opcode, imm);
`else
  assign legal_s = 1'b1;
`endif

  // Rejected bundles are replaced by a NOP tagged with the error bit.
  always_comb begin
    enc_word_s = NOP_WORD;
    enc_err_s  = 1'b1;
    if (class_ok_s && legal_s) begin
      enc_word_s = raw_word_s;
      enc_err_s  = 1'b0;
    end else begin
      enc_word_s = NOP_WORD;
      enc_err_s  = 1'b1;
    end
  end

  assign in_ready  = (count_r != 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;
  assign out_inst  = mem_word_r[rd_ptr_r];
  assign out_err   = mem_err_r[rd_ptr_r];
  assign err_cnt   = err_cnt_r;

  // FIFO storage and pointers; reset clears storage so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_word_r[0] <= 32'h0000_0000;
      mem_word_r[1] <= 32'h0000_0000;
      mem_err_r[0]  <= 1'b0;
      mem_err_r[1]  <= 1'b0;
      wr_ptr_r      <= 1'b0;
      rd_ptr_r      <= 1'b0;
    end else begin
      if (push_s) begin
        mem_word_r[wr_ptr_r] <= enc_word_s;
        mem_err_r[wr_ptr_r]  <= enc_err_s;
        wr_ptr_r             <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
    end
  end

  // Occupancy: simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Saturating count of bundles pushed as rejects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 8'h00;
    end else if (push_s && enc_err_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: randomized bundles against a queue-based reference model.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  itype;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [7:0]  err_cnt;

  int          total = 0;
  int          bad = 0;
  bit [31:0]   exp_word_q[$];
  bit          exp_err_q[$];
  int unsigned exp_cnt = 0;

  always #5 clk = ~clk;

  inst_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .itype(itype), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .err_cnt(err_cnt)
  );

  // Reference encoding built from bit positions with shifts and signed-range arithmetic.
  function automatic bit [32:0] ref_encode(input bit [2:0] t, input bit [6:0] op,
      input bit [4:0] d, input bit [4:0] s1, input bit [4:0] s2,
      input bit [2:0] f3, input bit [6:0] f7, input bit [31:0] im);
    bit [31:0] w;
    bit ok;
    int sv;
    sv = int'(im);
    ok = 1'b1;
    w = 32'h0;
    case (t)
      3'd0: w = (32'(f7) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12)
                | (32'(d) << 7) | 32'(op);
      3'd1: w = ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'(op);
      3'd2: w = (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | (32'(s1) << 15)
                | (32'(f3) << 12) | ((im & 32'h1F) << 7) | 32'(op);
      3'd3: w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(s2) << 20)
                | (32'(s1) << 15) | (32'(f3) << 12) | (((im >> 1) & 32'hF) << 8)
                | (((im >> 11) & 32'h1) << 7) | 32'(op);
      3'd4: w = (im & 32'hFFFF_F000) | (32'(d) << 7) | 32'(op);
      3'd5: w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                | (32'(d) << 7) | 32'(op);
      default: ok = 1'b0;
    endcase
`ifdef INST_ENCODER_CHECK_EN
    case (t)
      3'd0: ok = ok && (op == 7'h33);
      3'd1: ok = ok && (op inside {7'h13, 7'h67, 7'h03, 7'h73}) && sv >= -2048 && sv <= 2047;
      3'd2: ok = ok && (op == 7'h23) && sv >= -2048 && sv <= 2047;
      3'd3: ok = ok && (op == 7'h63) && sv >= -4096 && sv <= 4095 && (sv % 2 == 0);
      3'd4: ok = ok && (op inside {7'h37, 7'h17}) && (im % 4096 == 0);
      3'd5: ok = ok && (op == 7'h6F) && sv >= -1048576 && sv <= 1048575 && (sv % 2 == 0);
      default: ok = 1'b0;
    endcase
`endif
    if (!ok) return {1'b1, 32'h0000_0013};
    return {1'b0, w};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(exp_word_q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(exp_word_q.size() != 2));
    chk("err_cnt", 32'(err_cnt), exp_cnt);
    if (exp_word_q.size() != 0) begin
      chk("out_inst", out_inst, exp_word_q[0]);
      chk("out_err", 32'(out_err), 32'(exp_err_q[0]));
    end
  endtask

  // One clock: update the model with the handshakes seen at the edge, then check.
  task automatic cycle();
    bit acc, pop;
    bit [32:0] r;
    @(posedge clk);
    acc = in_valid && (exp_word_q.size() < 2);
    pop = out_ready && (exp_word_q.size() > 0);
    if (pop) begin
      void'(exp_word_q.pop_front());
      void'(exp_err_q.pop_front());
    end
    if (acc) begin
      r = ref_encode(itype, opcode, rd, rs1, rs2, funct3, funct7, imm);
      exp_word_q.push_back(r[31:0]);
      exp_err_q.push_back(r[32]);
      if (r[32] && exp_cnt < 255) exp_cnt++;
    end
    @(negedge clk);
    check_outputs();
  endtask

  function automatic bit [6:0] pick_opcode(input bit [2:0] t);
    bit [6:0] tab_i[4] = '{7'h13, 7'h67, 7'h03, 7'h73};
    case (t)
      3'd0: return 7'h33;
      3'd1: return tab_i[$urandom_range(0, 3)];
      3'd2: return 7'h23;
      3'd3: return 7'h63;
      3'd4: return ($urandom_range(0, 1) == 0) ? 7'h37 : 7'h17;
      3'd5: return 7'h6F;
      default: return 7'($urandom);
    endcase
  endfunction

  task automatic rand_fields();
    itype  = 3'($urandom_range(0, 7));
    opcode = ($urandom_range(0, 3) != 0) ? pick_opcode(itype) : 7'($urandom);
    rd     = 5'($urandom);
    rs1    = 5'($urandom);
    rs2    = 5'($urandom);
    funct3 = 3'($urandom);
    funct7 = 7'($urandom);
    case ($urandom_range(0, 4))
      0: imm = $urandom;
      1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      2: imm = $urandom & 32'hFFFF_F000;
      3: imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
      default: imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
    endcase
  endtask

  task automatic push_one(input bit [2:0] t, input bit [6:0] op, input bit [4:0] d,
      input bit [4:0] s1, input bit [4:0] s2, input bit [2:0] f3, input bit [6:0] f7,
      input bit [31:0] im);
    itype = t; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    itype = 3'd0; opcode = 7'h0; rd = 5'h0; rs1 = 5'h0; rs2 = 5'h0;
    funct3 = 3'h0; funct7 = 7'h0; imm = 32'h0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Directed encodings with known words.
    push_one(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'h0);
    chk("r_type_word", out_inst, 32'h4031_00B3);
    chk("r_type_err", 32'(out_err), 32'd0);
    cycle();
    push_one(3'd3, 7'h63, 5'd0, 5'd1, 5'd0, 3'd1, 7'h0, -32'sd4);
    chk("b_type_word", out_inst, 32'hFE00_9EE3);
    cycle();
    push_one(3'd3, 7'h63, 5'd0, 5'd1, 5'd0, 3'd1, 7'h0, 32'd3);
`ifdef INST_ENCODER_CHECK_EN
    chk("b_imm3_nop", out_inst, 32'h0000_0013);
    chk("b_imm3_err", 32'(out_err), 32'd1);
    chk("b_imm3_cnt", 32'(err_cnt), 32'd1);
`else
    chk("b_imm3_raw", out_inst, 32'h0000_9163);
    chk("b_imm3_err", 32'(out_err), 32'd0);
`endif
    cycle();
    push_one(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'h800);
    chk("j_type_word", out_inst, 32'h0010_00EF);
    cycle();
    push_one(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h0, 32'h1234_5000);
    chk("u_type_word", out_inst, 32'h1234_52B7);
    cycle();
    push_one(3'd6, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h0, 32'h0);
    chk("null_word", out_inst, 32'h0000_0013);
    chk("null_err", 32'(out_err), 32'd1);
    cycle();

    // Back-pressure: two accepts fill the FIFO, third bundle waits.
    out_ready = 1'b0;
    in_valid = 1'b1;
    rand_fields(); cycle();
    rand_fields(); cycle();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    rand_fields(); cycle(); cycle();
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (4) cycle();

    // Steady state at count 1 with push and pop every cycle.
    out_ready = 1'b0; in_valid = 1'b1;
    rand_fields(); cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_fields(); cycle();
      chk("steady_valid", 32'(out_valid), 32'd1);
      chk("steady_ready", 32'(in_ready), 32'd1);
    end
    itype = 3'd7; cycle(); cycle();

    // Reset pulse mid-stream.
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("mid_rst_out_inst", out_inst, 32'h0);
    exp_word_q.delete(); exp_err_q.delete(); exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    rand_fields(); cycle();
    chk("post_rst_accept", 32'(out_valid), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Error counter saturation.
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rand_fields();
      itype = 3'd6;
      cycle();
    end
    chk("err_sat", 32'(err_cnt), 32'hFF);
    in_valid = 1'b0;
    cycle(); cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: in_valid  in  1  field bundle valid; in_ready  out  1  encoder can accept.
REQ-004 SHALL have ports: itype  in  3  instruction class, codebase type codes (R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE, NULL_TYPE).
REQ-005 SHALL have ports: opcode  in  7; rd, rs1, rs2  in  5 each; funct3  in  3; funct7  in  7; imm  in  32  byte-offset/value, sign-extended.
REQ-006 SHALL have ports: out_valid  out  1; out_ready  in  1; out_inst  out  32  encoded RV32 word; out_err  out  1  entry failed legality check.
REQ-007 SHALL have ports: err_cnt  out  8  saturating count of rejected bundles.

Function
REQ-008 SHALL pack fields per class: R {funct7,rs2,rs1,funct3,rd,opcode}; I {imm[11:0],rs1,funct3,rd,opcode}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}.
REQ-009 SHALL pack B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; U {imm[31:12],rd,opcode}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-010 SHALL ignore fields unused by the class (e.g. funct7 for I, rs2 for U).
REQ-011 SHALL buffer encoded words in a 2-entry FIFO (word + err bit); count 0..2, 1-bit wrap-around read/write pointers.
REQ-012 SHALL accept a bundle on a rising edge with in_valid && in_ready; in_ready = (count != 2), independent of in_valid.
REQ-013 SHALL present FIFO head on out_inst/out_err; out_valid = (count != 0); pop on out_valid && out_ready.
REQ-014 Latency: bundle accepted at edge N SHALL appear at out_valid after edge N when FIFO was empty; no combinational in->out path.
REQ-015 Simultaneous push and pop with count 1 SHALL keep count 1; with count 2, push is blocked by in_ready=0, pop proceeds.
REQ-016 out_inst/out_err SHALL hold stable while out_valid && !out_ready.
REQ-017 Bundles with itype=NULL_TYPE or an undefined code SHALL be pushed as 32'h0000_0013 with out_err=1.

Reset
REQ-018 On rst_n low SHALL asynchronously clear count, pointers, err_cnt; out_valid=0, in_ready=1, out_err=0, out_inst=0 (head cleared).
REQ-019 Reset mid-transfer SHALL drop all buffered entries; no entry survives reset.
REQ-020 Deassertion SHALL take effect at the next clk edge; first accept possible on the first edge with rst_n high.

Configuration
REQ-021 Macro INST_ENCODER_CHECK_EN defined: SHALL check opcode/itype consistency (0110011->R; 0010011,1100111,0000011,1110011->I; 0110111,0010111->U; 1101111->J; 0100011->S; 1100011->B).
REQ-022 With INST_ENCODER_CHECK_EN: SHALL check imm range: I/S signed 12-bit; B signed 13-bit, imm[0]=0; J signed 21-bit, imm[0]=0; U imm[11:0]=0.
REQ-023 With INST_ENCODER_CHECK_EN: a failing bundle SHALL be pushed as 32'h0000_0013 with out_err=1 and err_cnt incremented, saturating at 8'hFF.
REQ-024 Without INST_ENCODER_CHECK_EN: only REQ-017 applies; opcode/imm never checked; err_cnt counts only REQ-017 rejects; valid-class words always encoded raw.

Verification
REQ-025 R_TYPE, opcode 0110011, rd=1, rs1=2, rs2=3, funct3=0, funct7=0x20 -> out_inst=32'h4031_00B3 one cycle later, out_err=0.
REQ-026 B_TYPE, opcode 1100011, rs1=1, rs2=0, funct3=1, imm=-4 -> out_inst=32'hFE00_9EE3; with CHECK_EN, imm=3 -> 32'h0000_0013, out_err=1, err_cnt=1.
REQ-027 J_TYPE, opcode 1101111, rd=1, imm=0x800 -> out_inst=32'h0010_00EF; U_TYPE lui rd=5, imm=0x12345000 -> 32'h1234_52B7.
REQ-028 out_ready=0, push 3 bundles back-to-back -> in_ready=0 after second accept, third held; raise out_ready -> words emerge in order, none lost or duplicated.
REQ-029 Count=1 with in_valid=out_ready=1 for 10 cycles -> count stays 1, one word out per cycle; rst_n pulse low mid-stream -> out_valid=0, in_ready=1, err_cnt=0 immediately.
REQ-030 With CHECK_EN, 300 NULL_TYPE bundles -> err_cnt saturates at 8'hFF; each output 32'h0000_0013 with out_err=1.
